dmem_arbiter: RTL and testbench

Arbitrates the single-port data memory between the pipeline's MEM stage and one external requester (loader/debug port). The CPU has priority. A bounded-wait counter guarantees the external port a grant within MAX_WAIT cycles by forcing a one-cycle pipeline stall. It sits between the EX/MEM register outputs, the data memory and the MEM/WB register.

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_wait_cnt.sv | 30 +++
 rtl/dmem_arbiter.sv | 90 +++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter between the MEM stage
// and the external loader/debug port.
package dmem_arbiter_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

  localparam int DEFAULT_MAX_WAIT = 4;
  localparam int DMEM_AW          = 32;
  localparam int DMEM_DW          = 32;

endpackage

// File: rtl/dmem_arbiter_wait_cnt.sv
// Saturating count of cycles the external requester has been denied; hit marks
// the last denied cycle before a grant must be forced.
module arb_wait_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;

  // Clear wins over increment so a grant always restarts the wait window.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(MAX_WAIT))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_hit = (r_cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has priority, the external port gets a
// forced grant (one-cycle pipeline stall) after MAX_WAIT denied cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic          i_clk,
  input  logic          i_pcrst,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_stall,
  input  logic          i_ext_req,
  input  logic          i_ext_we,
  input  logic [AW-1:0] i_ext_addr,
  input  logic [DW-1:0] i_ext_wdata,
  output logic          o_ext_gnt,
  output logic [DW-1:0] o_ext_rdata,
  output logic          o_ext_rvalid,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_we,
  input  logic [DW-1:0] i_mem_rdata
);

  arb_state_e r_state;
  arb_state_e w_next;
  logic       w_hit;
  logic       w_cpu_acc;

  arb_wait_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_cnt (
    .i_clk (i_clk),
    .i_rst (i_pcrst),
    .i_inc (i_ext_req & ~o_ext_gnt),
    .i_clr (o_ext_gnt | ~i_ext_req),
    .o_hit (w_hit)
  );

  always_ff @(posedge i_clk or posedge i_pcrst) begin
    if (i_pcrst) begin
      r_state <= NORMAL;
    end else begin
      r_state <= w_next;
    end
  end

  // FORCE lasts exactly one cycle; the counter is cleared during it, so a
  // second FORCE can never follow immediately.
  always_comb begin
    w_next = NORMAL;
    if ((r_state == NORMAL) && w_hit && i_ext_req && !o_ext_gnt) begin
      w_next = FORCE;
    end
  end

  always_comb begin
    o_cpu_stall = (r_state == FORCE);
    w_cpu_acc   = i_cpu_req && (r_state == NORMAL);
    o_ext_gnt   = (r_state == FORCE) ? i_ext_req : (i_ext_req && !i_cpu_req);
    o_mem_addr  = i_cpu_addr;
    o_mem_wdata = i_cpu_wdata;
    o_mem_we    = w_cpu_acc && i_cpu_we;
    if (o_ext_gnt && !w_cpu_acc) begin
      o_mem_addr  = i_ext_addr;
      o_mem_wdata = i_ext_wdata;
      o_mem_we    = i_ext_we;
    end
    o_cpu_rdata = i_mem_rdata;
  end

  always_ff @(posedge i_clk or posedge i_pcrst) begin
    if (i_pcrst) begin
      o_ext_rvalid <= 1'b0;
      o_ext_rdata  <= '0;
    end else begin
      o_ext_rvalid <= o_ext_gnt && !i_ext_we;
      if (o_ext_gnt && !i_ext_we) begin
        o_ext_rdata <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        pcrst;
  logic        cpuReq, cpuWe, extReq, extWe;
  logic [31:0] cpuAddr, cpuWdata, extAddr, extWdata;
  logic [31:0] cpuRdata, extRdata, memAddr, memWdata, memRdata;
  logic        cpuStall, extGnt, extRvalid, memWe;
  logic [31:0] memArray [0:255];
  int          nChecks = 0;
  int          nPass   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .i_clk(clk), .i_pcrst(pcrst),
    .i_cpu_req(cpuReq), .i_cpu_we(cpuWe), .i_cpu_addr(cpuAddr), .i_cpu_wdata(cpuWdata),
    .o_cpu_rdata(cpuRdata), .o_cpu_stall(cpuStall),
    .i_ext_req(extReq), .i_ext_we(extWe), .i_ext_addr(extAddr), .i_ext_wdata(extWdata),
    .o_ext_gnt(extGnt), .o_ext_rdata(extRdata), .o_ext_rvalid(extRvalid),
    .o_mem_addr(memAddr), .o_mem_wdata(memWdata), .o_mem_we(memWe),
    .i_mem_rdata(memRdata)
  );

  assign memRdata = memArray[memAddr[9:2]];

  always @(posedge clk) begin
    if (memWe) memArray[memAddr[9:2]] <= memWdata;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    pcrst = 1'b1;
    cpuReq = 0; cpuWe = 0; cpuAddr = 0; cpuWdata = 0;
    extReq = 0; extWe = 0; extAddr = 0; extWdata = 0;
    step();
    #1;
    nChecks++; if (cpuStall !== 1'b0) $display("[TB] FAIL rst_stall: got %0h want 0", cpuStall); else nPass++;
    nChecks++; if (extRvalid !== 1'b0) $display("[TB] FAIL rst_rvalid: got %0h want 0", extRvalid); else nPass++;
    nChecks++; if (extRdata !== 32'h0) $display("[TB] FAIL rst_rdata: got %0h want 0", extRdata); else nPass++;
    nChecks++; if (dut.u_wait_cnt.r_cnt !== 3'd0) $display("[TB] FAIL rst_cnt: got %0d want 0", dut.u_wait_cnt.r_cnt); else nPass++;
    nChecks++; if (memWe !== 1'b0) $display("[TB] FAIL rst_memwe: got %0h want 0", memWe); else nPass++;
    step();
    pcrst = 1'b0;
  endtask

  task automatic test_ext_write();
    step();
    cpuReq = 0; cpuAddr = 32'h44; cpuWdata = 32'h5555_0000;
    extReq = 1; extWe = 1; extAddr = 32'h10; extWdata = 32'hDEAD_BEEF;
    #1;
    nChecks++; if (extGnt !== 1'b1) $display("[TB] FAIL wr_gnt: got %0h want 1", extGnt); else nPass++;
    nChecks++; if (memWe !== 1'b1) $display("[TB] FAIL wr_memwe: got %0h want 1", memWe); else nPass++;
    nChecks++; if (memAddr !== 32'h10) $display("[TB] FAIL wr_addr: got %0h want 10", memAddr); else nPass++;
    nChecks++; if (memWdata !== 32'hDEAD_BEEF) $display("[TB] FAIL wr_wdata: got %0h want deadbeef", memWdata); else nPass++;
    step();
    extReq = 0; extWe = 0;
    cpuReq = 1; cpuWe = 0; cpuAddr = 32'h10;
    #1;
    nChecks++; if (cpuRdata !== 32'hDEAD_BEEF) $display("[TB] FAIL cpu_load: got %0h want deadbeef", cpuRdata); else nPass++;
    nChecks++; if (memWe !== 1'b0) $display("[TB] FAIL cpu_load_we: got %0h want 0", memWe); else nPass++;
    nChecks++; if (cpuStall !== 1'b0) $display("[TB] FAIL cpu_load_stall: got %0h want 0", cpuStall); else nPass++;
    step();
    cpuReq = 0;
  endtask

  task automatic test_ext_read();
    cpuAddr = 32'h80;
    extReq = 1; extWe = 0; extAddr = 32'h10;
    #1;
    nChecks++; if (extGnt !== 1'b1) $display("[TB] FAIL rd_gnt: got %0h want 1", extGnt); else nPass++;
    nChecks++; if (extRvalid !== 1'b0) $display("[TB] FAIL rd_rvalid_t0: got %0h want 0", extRvalid); else nPass++;
    nChecks++; if (memWe !== 1'b0) $display("[TB] FAIL rd_memwe: got %0h want 0", memWe); else nPass++;
    step();
    extReq = 0;
    #1;
    nChecks++; if (extRvalid !== 1'b1) $display("[TB] FAIL rd_rvalid_t1: got %0h want 1", extRvalid); else nPass++;
    nChecks++; if (extRdata !== 32'hDEAD_BEEF) $display("[TB] FAIL rd_rdata_t1: got %0h want deadbeef", extRdata); else nPass++;
    step();
    #1;
    nChecks++; if (extRvalid !== 1'b0) $display("[TB] FAIL rd_rvalid_t2: got %0h want 0", extRvalid); else nPass++;
    nChecks++; if (extRdata !== 32'hDEAD_BEEF) $display("[TB] FAIL rd_rdata_hold: got %0h want deadbeef", extRdata); else nPass++;
  endtask

  task automatic test_bounded_wait();
    step();
    cpuReq = 1; cpuWe = 0; cpuAddr = 32'h30;
    extReq = 1; extWe = 1; extAddr = 32'h30; extWdata = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      #1;
      nChecks++; if (extGnt !== 1'b0) $display("[TB] FAIL bw_gnt_c%0d: got %0h want 0", k, extGnt); else nPass++;
      nChecks++; if (cpuStall !== 1'b0) $display("[TB] FAIL bw_stall_c%0d: got %0h want 0", k, cpuStall); else nPass++;
      nChecks++; if (memAddr !== 32'h30 || memWe !== 1'b0) $display("[TB] FAIL bw_port_c%0d: got addr %0h we %0h want 30/0", k, memAddr, memWe); else nPass++;
    end
    step();
    #1;
    nChecks++; if (cpuStall !== 1'b1) $display("[TB] FAIL bw_stall_c4: got %0h want 1", cpuStall); else nPass++;
    nChecks++; if (extGnt !== 1'b1) $display("[TB] FAIL bw_gnt_c4: got %0h want 1", extGnt); else nPass++;
    nChecks++; if (memWe !== 1'b1) $display("[TB] FAIL bw_memwe_c4: got %0h want 1", memWe); else nPass++;
    nChecks++; if (memWdata !== 32'h1234_5678) $display("[TB] FAIL bw_wdata_c4: got %0h want 12345678", memWdata); else nPass++;
    step();
    extReq = 0; extWe = 0;
    #1;
    nChecks++; if (cpuStall !== 1'b0) $display("[TB] FAIL bw_stall_c5: got %0h want 0", cpuStall); else nPass++;
    nChecks++; if (cpuRdata !== 32'h1234_5678) $display("[TB] FAIL bw_cpu_c5: got %0h want 12345678", cpuRdata); else nPass++;
    step();
    cpuReq = 0;
  endtask

  task automatic test_cpu_drop();
    step();
    cpuReq = 1; cpuWe = 0; cpuAddr = 32'h30;
    extReq = 1; extWe = 0; extAddr = 32'h10;
    #1;
    nChecks++; if (extGnt !== 1'b0) $display("[TB] FAIL drop_gnt_c0: got %0h want 0", extGnt); else nPass++;
    step();
    #1;
    nChecks++; if (dut.u_wait_cnt.r_cnt !== 3'd1) $display("[TB] FAIL drop_cnt_c1: got %0d want 1", dut.u_wait_cnt.r_cnt); else nPass++;
    step();
    cpuReq = 0;
    #1;
    nChecks++; if (extGnt !== 1'b1) $display("[TB] FAIL drop_gnt_c2: got %0h want 1", extGnt); else nPass++;
    nChecks++; if (cpuStall !== 1'b0) $display("[TB] FAIL drop_stall_c2: got %0h want 0", cpuStall); else nPass++;
    step();
    extReq = 0; cpuReq = 1;
    #1;
    nChecks++; if (dut.u_wait_cnt.r_cnt !== 3'd0) $display("[TB] FAIL drop_cnt_c3: got %0d want 0", dut.u_wait_cnt.r_cnt); else nPass++;
    nChecks++; if (cpuStall !== 1'b0) $display("[TB] FAIL drop_stall_c3: got %0h want 0", cpuStall); else nPass++;
    nChecks++; if (extRvalid !== 1'b1 || extRdata !== 32'hDEAD_BEEF) $display("[TB] FAIL drop_rd_c3: got v%0h %0h want v1 deadbeef", extRvalid, extRdata); else nPass++;
    step();
    cpuReq = 0;
  endtask

  task automatic test_back_to_back();
    int  stalls = 0;
    logic prevStall = 1'b0;
    logic expHit;
    step();
    cpuReq = 1; cpuWe = 0; cpuAddr = 32'h30;
    extReq = 1; extWe = 1; extAddr = 32'h40; extWdata = 32'hA5A5_0000;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step();
      extWdata = 32'hA5A5_0000 + k;
      #1;
      expHit = ((k % 5) == 4);
      nChecks++; if (extGnt !== expHit) $display("[TB] FAIL b2b_gnt_c%0d: got %0h want %0h", k, extGnt, expHit); else nPass++;
      nChecks++; if (cpuStall !== expHit) $display("[TB] FAIL b2b_stall_c%0d: got %0h want %0h", k, cpuStall, expHit); else nPass++;
      nChecks++; if (prevStall === 1'b1 && cpuStall === 1'b1) $display("[TB] FAIL b2b_double_c%0d: got stall 1 twice want 0", k); else nPass++;
      if (cpuStall === 1'b1) stalls++;
      prevStall = cpuStall;
    end
    nChecks++; if (stalls != 4) $display("[TB] FAIL b2b_count: got %0d want 4", stalls); else nPass++;
    step();
    cpuReq = 0; extReq = 0; extWe = 0;
    step();
  endtask

  task automatic test_reset_mid_force();
    cpuReq = 0; extReq = 1; extWe = 0; extAddr = 32'h10;
    step();
    extReq = 0;
    #1;
    nChecks++; if (extRvalid !== 1'b1) $display("[TB] FAIL mrst_rvalid_pre: got %0h want 1", extRvalid); else nPass++;
    #2; pcrst = 1'b1; #1;
    nChecks++; if (extRvalid !== 1'b0) $display("[TB] FAIL mrst_rvalid: got %0h want 0", extRvalid); else nPass++;
    nChecks++; if (extRdata !== 32'h0) $display("[TB] FAIL mrst_rdata: got %0h want 0", extRdata); else nPass++;
    step();
    pcrst = 1'b0;
    cpuReq = 1; cpuAddr = 32'h30; extReq = 1; extWe = 0; extAddr = 32'h10;
    for (int k = 1; k <= 4; k++) step();
    #1;
    nChecks++; if (cpuStall !== 1'b1) $display("[TB] FAIL mrst_force: got %0h want 1", cpuStall); else nPass++;
    #2; pcrst = 1'b1; #1;
    nChecks++; if (cpuStall !== 1'b0) $display("[TB] FAIL mrst_stall: got %0h want 0", cpuStall); else nPass++;
    nChecks++; if (dut.u_wait_cnt.r_cnt !== 3'd0) $display("[TB] FAIL mrst_cnt: got %0d want 0", dut.u_wait_cnt.r_cnt); else nPass++;
    nChecks++; if (extGnt !== 1'b0) $display("[TB] FAIL mrst_gnt: got %0h want 0", extGnt); else nPass++;
    step();
    pcrst = 1'b0; cpuReq = 0; extReq = 0;
    step();
    #1;
    nChecks++; if (cpuStall !== 1'b0 || extRvalid !== 1'b0) $display("[TB] FAIL mrst_after: got stall %0h rvalid %0h want 0/0", cpuStall, extRvalid); else nPass++;
    extReq = 1; #1;
    nChecks++; if (extGnt !== 1'b1) $display("[TB] FAIL mrst_normal_gnt: got %0h want 1", extGnt); else nPass++;
    step();
    extReq = 0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memArray[i] = 32'h0;
    test_reset();
    test_ext_write();
    test_ext_read();
    test_bounded_wait();
    test_cpu_drop();
    test_back_to_back();
    test_reset_mid_force();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
